// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the MEM stage: data width, load/store funct3
//   encodings, the access FSM state type and small helpers for access size,
//   byte-lane enables and alignment.
//   Used by mem_access_stage and dmem_array.
package mem_stage_pkg;

    localparam int XLEN = 64;

    // Load encodings (funct3)
    localparam logic [2:0] F3_LB     = 3'b000;
    localparam logic [2:0] F3_LH     = 3'b001;
    localparam logic [2:0] F3_LW     = 3'b010;
    localparam logic [2:0] F3_LD     = 3'b011;
    localparam logic [2:0] F3_LBU    = 3'b100;
    localparam logic [2:0] F3_LHU    = 3'b101;
    localparam logic [2:0] F3_LWU    = 3'b110;
    localparam logic [2:0] F3_LD_ALT = 3'b111;   // unused encoding, behaves as ld

    // Store encodings (funct3); 1xx behaves as sd
    localparam logic [2:0] F3_SB     = 3'b000;
    localparam logic [2:0] F3_SH     = 3'b001;
    localparam logic [2:0] F3_SW     = 3'b010;
    localparam logic [2:0] F3_SD     = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Number of bytes touched by an access. Loads only look at funct3[1:0]
    // (the top bit selects zero extension); stores fold every 1xx onto sd.
    function automatic logic [3:0] access_bytes(input logic [2:0] f3,
                                                input logic       is_store);
        logic [3:0] n;
        n = 4'd8;
        if (!(is_store && f3[2])) begin
            case (f3[1:0])
                2'b00:   n = 4'd1;
                2'b01:   n = 4'd2;
                2'b10:   n = 4'd4;
                default: n = 4'd8;
            endcase
        end
        return n;
    endfunction

    // One enable per byte lane, lanes 0..size-1 active.
    function automatic logic [7:0] lane_enables(input logic [3:0] size);
        logic [7:0] be;
        be = '0;
        for (int i = 0; i < 8; i++) begin
            be[i] = (4'(i) < size);
        end
        return be;
    endfunction

    // Natural alignment check on the low address bits.
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic       is_store,
                                           input logic [2:0] addr_lo);
        logic [3:0] size;
        size = access_bytes(f3, is_store);
        return ((size == 4'd2) && (addr_lo[0]   != 1'b0))  ||
               ((size == 4'd4) && (addr_lo[1:0] != 2'b00)) ||
               ((size == 4'd8) && (addr_lo      != 3'b000));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array
//   Byte-addressed data memory of MEM_BYTES bytes. Presents an 8-byte
//   little-endian window starting at addr; every lane computes its own byte
//   index modulo the array size, so an access near the top of the array
//   wraps byte by byte to the bottom.
//   Ports:
//     clk    - clock, writes on rising edge
//     addr   - byte index of lane 0 (already reduced to the array size)
//     we     - per-lane write enables (lane i -> byte addr+i)
//     wdata  - write data, lane i in bits [8i+7:8i]
//     rdata  - combinational read of the 8-byte window
//   Contents are never reset.
module dmem_array
    import mem_stage_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic                         clk,
    input  logic [$clog2(MEM_BYTES)-1:0] addr,
    input  logic [7:0]                   we,
    input  logic [XLEN-1:0]              wdata,
    output logic [XLEN-1:0]              rdata
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]    mem [MEM_BYTES];
    logic [AW-1:0] lane_idx [8];

    // Wrapping falls out of the AW-bit addition.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_idx[gi]          = addr + AW'(gi);
            assign rdata[8*gi +: 8]      = mem[lane_idx[gi]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (we[i]) begin
                mem[lane_idx[i]] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM stage of the 64-bit five-stage pipeline. Performs loads and stores
//   against dmem_array with a fixed access latency, stalling the upstream
//   stages while an access is in flight, and forwards writeback controls to
//   MEM/WB.
//   Parameters:
//     MEM_BYTES   - data memory size in bytes (power of two)
//     MEM_LATENCY - stalled cycles per access (>= 1)
//   Ports:
//     clk, reset                - clock; asynchronous active-high reset
//     ALU_Resultin              - effective address / ALU result
//     WriteDatain               - store data (low bytes used)
//     funct3                    - access size and signedness
//     MemRead, MemWrite         - access request
//     MemtoReg, RegWrite, rd    - writeback controls from EX/MEM
//     ReadDataout               - registered, extended load data
//     ALU_Resultout, rdOut,
//     MemtoRegOut, RegWriteOut  - pass-through to MEM/WB (RegWrite bubbled
//                                 while stalled)
//     stall                     - freezes PC, IF/ID, ID/EX and EX/MEM
//     misalign_err              - misaligned-access trap flag
//   Build option: define MISALIGN_TRAP_EN to trap misaligned accesses instead
//   of performing them byte-wise; without it misalign_err is constant 0.
//
//   Access timeline (MEM_LATENCY = L): the IDLE cycle that sees the request
//   plus L-1 WAIT cycles are stalled; the array is accessed on the edge into
//   RESP; RESP is unstalled so MEM/WB captures the result at its end.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_BYTES   = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] ALU_Resultin,
    input  logic [XLEN-1:0] WriteDatain,
    input  logic [2:0]      funct3,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            MemtoReg,
    input  logic            RegWrite,
    input  logic [4:0]      rd,
    output logic [XLEN-1:0] ReadDataout,
    output logic [XLEN-1:0] ALU_Resultout,
    output logic [4:0]      rdOut,
    output logic            MemtoRegOut,
    output logic            RegWriteOut,
    output logic            stall,
    output logic            misalign_err
);

    localparam int AW = $clog2(MEM_BYTES);
    // Counter holds MEM_LATENCY-1 at most.
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [AW-1:0]   addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [2:0]      f3_reg;
    logic            is_load_reg;
    logic            is_store_reg;
    logic [XLEN-1:0] rdata_reg;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic req;
    logic trap;
    logic start;
    logic fire;

    assign req = MemRead | MemWrite;

`ifdef MISALIGN_TRAP_EN
    // A store wins over a load when both are requested, so alignment is
    // judged with the store size in that case.
    assign trap = !reset && (state_reg == IDLE) && req &&
                  is_misaligned(funct3, MemWrite, ALU_Resultin[2:0]);
`else
    assign trap = 1'b0;
`endif

    assign start = (state_reg == IDLE) && req && !trap;

    // Edge that enters RESP: straight from IDLE at latency 1, otherwise the
    // last WAIT cycle (counter about to reach zero).
    assign fire = ((MEM_LATENCY == 1) && start) ||
                  ((state_reg == WAIT) && (cnt_reg == CW'(1)));

    // ------------------------------------------------------------------
    // Access operands: live inputs in IDLE, latched copy afterwards
    // ------------------------------------------------------------------
    logic            live;
    logic [AW-1:0]   acc_idx;
    logic [XLEN-1:0] acc_wdata;
    logic [2:0]      acc_f3;
    logic            acc_load;
    logic            acc_store;

    assign live      = (state_reg == IDLE);
    assign acc_idx   = live ? ALU_Resultin[AW-1:0]     : addr_reg;
    assign acc_wdata = live ? WriteDatain              : wdata_reg;
    assign acc_f3    = live ? funct3                   : f3_reg;
    assign acc_load  = live ? (MemRead & ~MemWrite)    : is_load_reg;
    assign acc_store = live ? MemWrite                 : is_store_reg;

    // ------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------
    logic [7:0]      mem_we;
    logic [XLEN-1:0] mem_rdata;

    // Reset gating keeps a latency-1 store from landing while reset is high.
    assign mem_we = (fire && acc_store && !reset)
                  ? lane_enables(access_bytes(acc_f3, 1'b1))
                  : 8'h00;

    dmem_array #(
        .MEM_BYTES (MEM_BYTES)
    ) u_dmem (
        .clk   (clk),
        .addr  (acc_idx),
        .we    (mem_we),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    // ------------------------------------------------------------------
    // Load extension
    // ------------------------------------------------------------------
    logic [XLEN-1:0] load_ext;

    always_comb begin
        load_ext = mem_rdata;
        case (acc_f3)
            F3_LB:   load_ext = {{56{mem_rdata[7]}},  mem_rdata[7:0]};
            F3_LH:   load_ext = {{48{mem_rdata[15]}}, mem_rdata[15:0]};
            F3_LW:   load_ext = {{32{mem_rdata[31]}}, mem_rdata[31:0]};
            F3_LBU:  load_ext = {56'd0, mem_rdata[7:0]};
            F3_LHU:  load_ext = {48'd0, mem_rdata[15:0]};
            F3_LWU:  load_ext = {32'd0, mem_rdata[31:0]};
            default: load_ext = mem_rdata;      // ld and its 111 alias
        endcase
    end

    // ------------------------------------------------------------------
    // FSM, counter, request latch and load data register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            f3_reg       <= '0;
            is_load_reg  <= 1'b0;
            is_store_reg <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            // Load-only accesses update the data; stores (including a
            // simultaneous read+write) leave the previous load data in place.
            if (fire && acc_load) begin
                rdata_reg <= load_ext;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        addr_reg     <= ALU_Resultin[AW-1:0];
                        wdata_reg    <= WriteDatain;
                        f3_reg       <= funct3;
                        is_load_reg  <= MemRead & ~MemWrite;
                        is_store_reg <= MemWrite;
                        cnt_reg      <= CW'(MEM_LATENCY - 1);
                        state_reg    <= (MEM_LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    // The held instruction is still on the inputs here;
                    // returning to IDLE unconditionally avoids a re-issue.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall         = !reset && (start || (state_reg == WAIT));
    assign misalign_err  = trap;
    assign ReadDataout   = rdata_reg;

    assign ALU_Resultout = reset ? '0    : ALU_Resultin;
    assign rdOut         = reset ? 5'd0  : rd;
    assign MemtoRegOut   = !reset && MemtoReg;
    // MEM/WB sees a bubble while stalled or when a misaligned access traps.
    assign RegWriteOut   = !reset && RegWrite && !stall && !trap;

endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
module tb_mem_access_stage;

    localparam int MEM_BYTES   = 256;
    localparam int MEM_LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] ALU_Resultin;
    logic [63:0] WriteDatain;
    logic [2:0]  funct3;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [63:0] ReadDataout;
    logic [63:0] ALU_Resultout;
    logic [4:0]  rdOut;
    logic        MemtoRegOut;
    logic        RegWriteOut;
    logic        stall;
    logic        misalign_err;

    mem_access_stage #(
        .MEM_BYTES   (MEM_BYTES),
        .MEM_LATENCY (MEM_LATENCY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ALU_Resultin  (ALU_Resultin),
        .WriteDatain   (WriteDatain),
        .funct3        (funct3),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .MemtoReg      (MemtoReg),
        .RegWrite      (RegWrite),
        .rd            (rd),
        .ReadDataout   (ReadDataout),
        .ALU_Resultout (ALU_Resultout),
        .rdOut         (rdOut),
        .MemtoRegOut   (MemtoRegOut),
        .RegWriteOut   (RegWriteOut),
        .stall         (stall),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: plain byte array plus the last value a load returned.
    byte unsigned model_mem [MEM_BYTES];
    logic [63:0]  last_load;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Bytes per access from the funct3 tables.
    function automatic int size_of(input logic [2:0] f3, input bit is_store);
        if (is_store) return (f3 >= 3'd3) ? 8 : (1 << f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic int byte_index(input logic [63:0] addr, input int i);
        return int'((addr + 64'(i)) % MEM_BYTES);
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [2:0] f3);
        int          n;
        logic [63:0] v;
        n = size_of(f3, 1'b0);
        v = 64'd0;
        for (int i = 0; i < n; i++) begin
            v = v | (64'(model_mem[byte_index(addr, i)]) << (8 * i));
        end
        // lb/lh/lw sign-extend; ld is already full width; 1xx zero-extend.
        if (f3 <= 3'd2 && v[8*n-1]) begin
            v = v | (~64'd0 << (8 * n));
        end
        return v;
    endfunction

    task automatic model_store(input logic [63:0] addr, input logic [2:0] f3, input logic [63:0] wd);
        int n;
        n = size_of(f3, 1'b1);
        for (int i = 0; i < n; i++) begin
            model_mem[byte_index(addr, i)] = wd[8*i +: 8];
        end
    endtask

    task automatic drive_nop();
        MemRead = 0; MemWrite = 0; funct3 = 0; ALU_Resultin = 0;
        WriteDatain = 0; RegWrite = 0; MemtoReg = 0; rd = 0;
    endtask

    // One instruction through the stage. Called at posedge+1, returns at
    // posedge+1 with the inputs back at a no-op.
    task automatic run_op(input string tag, input bit mr, input bit mw, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input bit rw, input bit m2r, input logic [4:0] rdi);
        int cycles;
        MemRead = mr; MemWrite = mw; funct3 = f3; ALU_Resultin = addr;
        WriteDatain = wd; RegWrite = rw; MemtoReg = m2r; rd = rdi;
        #1;
        check({tag, ":alu_pass"}, ALU_Resultout, addr);
        check({tag, ":rd_pass"}, 64'(rdOut), 64'(rdi));
        check({tag, ":m2r_pass"}, 64'(MemtoRegOut), 64'(m2r));
        if (!(mr || mw)) begin
            check({tag, ":nomem_stall"}, 64'(stall), 64'd0);
            check({tag, ":nomem_regwrite"}, 64'(RegWriteOut), 64'(rw));
            $display("op %s nomem alu=%h rd=%0d", tag, addr, rdi);
            @(posedge clk); #1;
            drive_nop();
            return;
        end
`ifdef MISALIGN_TRAP_EN
        if ((addr % 64'(size_of(f3, mw))) != 0) begin
            check({tag, ":trap_err"}, 64'(misalign_err), 64'd1);
            check({tag, ":trap_stall"}, 64'(stall), 64'd0);
            check({tag, ":trap_regwrite"}, 64'(RegWriteOut), 64'd0);
            $display("op %s trapped addr=%h f3=%0d", tag, addr, f3);
            @(posedge clk); #1;
            drive_nop();
            return;
        end
`endif
        check({tag, ":misalign_err"}, 64'(misalign_err), 64'd0);
        cycles = 0;
        while (stall === 1'b1 && cycles < 20) begin
            check({tag, ":bubble"}, 64'(RegWriteOut), 64'd0);
            cycles++;
            @(posedge clk); #1;
        end
        check({tag, ":stall_cycles"}, 64'(cycles), 64'(MEM_LATENCY));
        if (mw) model_store(addr, f3, wd);
        else    last_load = model_load(addr, f3);
        check({tag, ":read_data"}, ReadDataout, last_load);
        check({tag, ":resp_regwrite"}, 64'(RegWriteOut), 64'(rw));
        $display("op %s rd=%b wr=%b f3=%0d addr=%h wdata=%h -> data=%h stall=%0d",
                 tag, mr, mw, f3, addr, wd, ReadDataout, cycles);
        @(posedge clk); #1;
        drive_nop();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        int          kind;
        logic [2:0]  f;

        last_load = 64'd0;

        // Reset with live-looking inputs: everything must read back as zero.
        reset = 1'b1;
        MemRead = 1; MemWrite = 0; funct3 = 3; ALU_Resultin = 64'h1234_5678_9ABC_DEF0;
        WriteDatain = 64'hFFFF; RegWrite = 1; MemtoReg = 1; rd = 5'd7;
        #2;
        check("rst:stall", 64'(stall), 64'd0);
        check("rst:read_data", ReadDataout, 64'd0);
        check("rst:alu", ALU_Resultout, 64'd0);
        check("rst:rd", 64'(rdOut), 64'd0);
        check("rst:m2r", 64'(MemtoRegOut), 64'd0);
        check("rst:regwrite", 64'(RegWriteOut), 64'd0);
        check("rst:misalign", 64'(misalign_err), 64'd0);
        drive_nop();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        // Fill the whole array so later loads never see uninitialised bytes.
        for (int i = 0; i < MEM_BYTES / 8; i++) begin
            run_op("init_sd", 0, 1, 3'd3, 64'(8 * i), {$urandom, $urandom}, 0, 0, 0);
        end

        // Directed cases.
        run_op("sd10", 0, 1, 3'd3, 64'h10, 64'h1122_3344_5566_7788, 0, 0, 0);
        run_op("ld10", 1, 0, 3'd3, 64'h10, 0, 1, 1, 5'd5);
        check("ld10_const", ReadDataout, 64'h1122_3344_5566_7788);
        run_op("lb10", 1, 0, 3'd0, 64'h10, 0, 1, 1, 5'd6);
        check("lb10_const", ReadDataout, 64'hFFFF_FFFF_FFFF_FF88);
        run_op("lbu10", 1, 0, 3'd4, 64'h10, 0, 1, 1, 5'd6);
        check("lbu10_const", ReadDataout, 64'h88);
        run_op("lh16", 1, 0, 3'd1, 64'h16, 0, 1, 1, 5'd6);
        check("lh16_const", ReadDataout, 64'h1122);
        run_op("sw20", 0, 1, 3'd2, 64'h20, 64'h0BAD_F00D_DEAD_BEEF, 0, 0, 0);
        check("sw_hold", ReadDataout, 64'h1122);
        run_op("lw20", 1, 0, 3'd2, 64'h20, 0, 1, 1, 5'd8);
        check("lw20_const", ReadDataout, 64'hFFFF_FFFF_DEAD_BEEF);
        run_op("lwu20", 1, 0, 3'd6, 64'h20, 0, 1, 1, 5'd8);
        check("lwu20_const", ReadDataout, 64'h0000_0000_DEAD_BEEF);
        run_op("lw21_misaligned", 1, 0, 3'd2, 64'h21, 0, 1, 1, 5'd9);
        run_op("ld7_alias", 1, 0, 3'd7, 64'h10, 0, 1, 1, 5'd9);
        run_op("sdFF_wrap", 0, 1, 3'd3, 64'hFF, 64'hA1A2_A3A4_A5A6_A7A8, 0, 0, 0);
        run_op("ldFF_wrap", 1, 0, 3'd3, 64'hFF, 0, 1, 1, 5'd10);
        run_op("ld00_after_wrap", 1, 0, 3'd3, 64'h0, 0, 1, 1, 5'd10);
        run_op("alias_hi_addr", 1, 0, 3'd3, 64'hABCD_0000_0000_0110, 0, 1, 1, 5'd11);
        run_op("rw_both", 1, 1, 3'd0, 64'h40, 64'h5A, 0, 0, 0);
        run_op("lbu40", 1, 0, 3'd4, 64'h40, 0, 1, 1, 5'd12);
        check("lbu40_const", ReadDataout, 64'h5A);
        run_op("nonmem", 0, 0, 3'd0, 64'h5, 0, 1, 0, 5'd3);

        // Reset in the middle of a store: store dropped, outputs cleared.
        run_op("sd30_zero", 0, 1, 3'd3, 64'h30, 64'd0, 0, 0, 0);
        MemWrite = 1; funct3 = 3'd3; ALU_Resultin = 64'h30; WriteDatain = 64'hAB;
        RegWrite = 1; MemtoReg = 1; rd = 5'd4;
        #1;
        check("midrst:stall_idle", 64'(stall), 64'd1);
        @(posedge clk); #1;
        check("midrst:stall_wait", 64'(stall), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst:stall", 64'(stall), 64'd0);
        check("midrst:read_data", ReadDataout, 64'd0);
        check("midrst:alu", ALU_Resultout, 64'd0);
        check("midrst:rd", 64'(rdOut), 64'd0);
        check("midrst:m2r", 64'(MemtoRegOut), 64'd0);
        check("midrst:regwrite", 64'(RegWriteOut), 64'd0);
        $display("op midrst reset asserted during WAIT");
        last_load = 64'd0;
        drive_nop();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op("ld30_after_rst", 1, 0, 3'd3, 64'h30, 0, 1, 1, 5'd4);
        check("ld30_const", ReadDataout, 64'd0);

        // Randomised mix against the model.
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 9);
            f    = 3'($urandom_range(0, 7));
            a    = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a = a & ~64'd7;
            d    = {$urandom, $urandom};
            if (kind <= 1)
                run_op("rnd_nop", 0, 0, f, a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom));
            else if (kind <= 5)
                run_op("rnd_ld", 1, 0, f, a, d, 1, 1, 5'($urandom));
            else if (kind <= 8)
                run_op("rnd_st", 0, 1, f, a, d, 0, 0, 5'($urandom));
            else
                run_op("rnd_rw", 1, 1, f, a, d, 0, 0, 5'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
